// File: rtl/rvx_pkg.sv
// Shared fetch-path definitions: bus width, NOP encoding and fetch FSM states.
package rvx_pkg;

  localparam int BUS_W = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/inst/pc with load, hold and kill.
// Kill wins over load so a wrong-path word can never be captured.
module if_id_reg
  import rvx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             kill,
  input  logic [BUS_W-1:0] inst_d,
  input  logic [BUS_W-1:0] pc_d,
  output logic             valid,
  output logic [BUS_W-1:0] inst,
  output logic [BUS_W-1:0] pc
);

  // Register update: kill clears valid, load captures, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= NOP;
      pc    <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= inst_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, BOOT/RUN/HALT sequencing and the IF/ID register.
// Optional macro RVX_FETCH_CHK_EN enables misaligned-redirect and range faults
// (sticky fault_o, HALT until reset). Without it, redirect targets are forced
// word-aligned and every address is fetched unchecked.
//
// state | meaning
// BOOT  | one cycle after reset release, no capture (a redirect still loads pc)
// RUN   | fetch one word per free slot, redirects kill the IF/ID word
// HALT  | fault seen, pc frozen, redirects ignored, exit only by reset
module fetch_unit
  import rvx_pkg::*;
#(
  parameter logic [BUS_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int               MEM_SIZE = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [BUS_W-1:0] im_addr_o,
  input  logic [BUS_W-1:0] im_inst_i,
  input  logic             redirect_valid_i,
  input  logic [BUS_W-1:0] redirect_pc_i,
  input  logic             id_ready_i,
  output logic             if_valid_o,
  output logic [BUS_W-1:0] if_inst_o,
  output logic [BUS_W-1:0] if_pc_o,
  output logic             fault_o
);

  // Highest address whose whole word lies inside instruction memory.
  localparam logic [BUS_W-1:0] LAST_PC = BUS_W'(MEM_SIZE - 4);

  fetch_state_e     state_q;
  logic [BUS_W-1:0] pc_q;
  logic [BUS_W-1:0] redir_pc;
  logic             fault_q;
  logic             slot_free;
  logic             bad_target;
  logic             out_of_range;
  logic             fault_hit;
  logic             capture;
  logic             kill;

  assign im_addr_o = pc_q;
  assign fault_o   = fault_q;
  assign slot_free = !if_valid_o || id_ready_i;

`ifdef RVX_FETCH_CHK_EN
  assign redir_pc     = redirect_pc_i;
  assign bad_target   = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign out_of_range = (pc_q > LAST_PC);
`else
  logic unused_chk;
  assign redir_pc     = {redirect_pc_i[BUS_W-1:2], 2'b00};
  assign bad_target   = 1'b0;
  assign out_of_range = 1'b0;
  assign unused_chk   = ^{redirect_pc_i[1:0], LAST_PC};
`endif

  // A redirect overrides the range check: we are leaving the current pc anyway.
  assign fault_hit = ((state_q != ST_HALT) && bad_target) ||
                     ((state_q == ST_RUN) && !redirect_valid_i && out_of_range);

  assign capture = (state_q == ST_RUN) && !redirect_valid_i && slot_free && !fault_hit;
  assign kill    = ((state_q == ST_RUN) && redirect_valid_i) || fault_hit ||
                   (state_q == ST_HALT);

  // Fetch sequencing: state, program counter and sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (fault_hit) begin
            fault_q <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            if (redirect_valid_i) pc_q <= redir_pc;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fault_hit) begin
            fault_q <= 1'b1;
            state_q <= ST_HALT;
          end else if (redirect_valid_i) begin
            pc_q <= redir_pc;
          end else if (slot_free) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (capture),
    .kill   (kill),
    .inst_d (im_inst_i),
    .pc_d   (pc_q),
    .valid  (if_valid_o),
    .inst   (if_inst_o),
    .pc     (if_pc_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle model + consumed-stream scoreboard,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

`ifdef RVX_FETCH_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int MEM_SIZE = 128;

  logic        clk;
  logic        rst_n;
  logic [31:0] im_addr_o;
  logic [31:0] im_inst_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        fault_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_checks = 1'b0;

  fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(MEM_SIZE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .im_addr_o        (im_addr_o),
    .im_inst_i        (im_inst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_ready_i       (id_ready_i),
    .if_valid_o       (if_valid_o),
    .if_inst_o        (if_inst_o),
    .if_pc_o          (if_pc_o),
    .fault_o          (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0513;
    if (a == 32'h4) return 32'h0015_8593;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  assign im_inst_i = memf(im_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 boot, 1 run, 2 halted.
  int          m_phase;
  logic [31:0] m_pc, m_inst, m_outpc, exp_next;
  logic        m_valid, m_fault;
  // DUT outputs sampled at the previous falling edge (for the stream check).
  logic        s_valid;
  logic [31:0] s_pc, s_inst;

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_valid = 1'b0; m_inst = 32'h13;
    m_outpc = 32'h0; m_fault = 1'b0; exp_next = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic        misal;
    tgt   = CHK ? redirect_pc_i : (redirect_pc_i & ~32'h3);
    misal = CHK && redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
    // Consumed-stream check: each accepted word follows the previous one or a redirect.
    if (run_checks && s_valid && id_ready_i) begin
      chk("stream_pc", s_pc, exp_next);
      chk("stream_inst", s_inst, memf(s_pc));
      exp_next = s_pc + 32'd4;
    end
    if (redirect_valid_i && m_phase != 2) exp_next = tgt;
    if (m_phase == 0) begin
      if (misal) begin m_fault = 1'b1; m_phase = 2; end
      else begin
        if (redirect_valid_i) m_pc = tgt;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (misal || (CHK && !redirect_valid_i && m_pc > MEM_SIZE - 4)) begin
        m_fault = 1'b1; m_phase = 2; m_valid = 1'b0;
      end else if (redirect_valid_i) begin
        m_pc = tgt; m_valid = 1'b0;
      end else if (!m_valid || id_ready_i) begin
        m_inst = memf(m_pc); m_outpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: DUT vs model every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (run_checks) begin
        chk("if_valid", {31'b0, if_valid_o}, {31'b0, m_valid});
        chk("im_addr", im_addr_o, m_pc);
        chk("fault", {31'b0, fault_o}, {31'b0, m_fault});
        if (m_valid) begin
          chk("if_inst", if_inst_o, m_inst);
          chk("if_pc", if_pc_o, m_outpc);
        end
      end
      s_valid = if_valid_o; s_pc = if_pc_o; s_inst = if_inst_o;
    end
  end

  // Apply inputs now (just after a falling edge), return after the next falling edge.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid_i = rv; redirect_pc_i = rpc; id_ready_i = rdy;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid_o}, 32'h0);
    chk({tag, "_inst"}, if_inst_o, 32'h0000_0013);
    chk({tag, "_pc"}, if_pc_o, 32'h0);
    chk({tag, "_addr"}, im_addr_o, 32'h0);
    chk({tag, "_fault"}, {31'b0, fault_o}, 32'h0);
  endtask

  // Asynchronous reset pulse, checked before any clock edge can act.
  task automatic pulse_reset(input bit check_now);
    #2 rst_n = 1'b0;
    #1;
    if (check_now) check_reset_vals("async_rst");
    redirect_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] hold_inst, hold_pc, hold_addr, rpc;
  logic [1:0]  lo;

  initial begin
    rst_n = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    run_checks = 1'b1;

    // Reset release: boot cycle, then words at 0 and 4 back to back.
    step(1'b0, 32'h0, 1'b1);
    chk("boot_valid", {31'b0, if_valid_o}, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("first_valid", {31'b0, if_valid_o}, 32'h1);
    chk("first_pc", if_pc_o, 32'h0);
    chk("first_inst", if_inst_o, 32'h0050_0513);
    step(1'b0, 32'h0, 1'b1);
    chk("second_pc", if_pc_o, 32'h4);
    chk("second_inst", if_inst_o, 32'h0015_8593);

    // Stall three cycles with a valid word held.
    step(1'b0, 32'h0, 1'b1);
    hold_inst = if_inst_o; hold_pc = if_pc_o; hold_addr = im_addr_o;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("stall_inst", if_inst_o, hold_inst);
      chk("stall_pc", if_pc_o, hold_pc);
      chk("stall_addr", im_addr_o, hold_addr);
    end
    step(1'b0, 32'h0, 1'b1);
    chk("resume_pc", if_pc_o, 32'hC);
    chk("resume_addr", im_addr_o, 32'h10);

    // Redirect to 0x4 from pc 0x10.
    step(1'b1, 32'h4, 1'b1);
    chk("redir_valid", {31'b0, if_valid_o}, 32'h0);
    chk("redir_addr", im_addr_o, 32'h4);
    step(1'b0, 32'h0, 1'b1);
    chk("redir_pc", if_pc_o, 32'h4);
    chk("redir_inst", if_inst_o, 32'h0015_8593);

`ifdef RVX_FETCH_CHK_EN
    // Misaligned redirect faults and halts; later redirects are ignored.
    step(1'b1, 32'h6, 1'b1);
    chk("flt_fault", {31'b0, fault_o}, 32'h1);
    chk("flt_valid", {31'b0, if_valid_o}, 32'h0);
    hold_addr = im_addr_o;
    step(1'b1, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("halt_addr", im_addr_o, hold_addr);
    chk("halt_fault", {31'b0, fault_o}, 32'h1);
    pulse_reset(1'b0);
    chk("clr_fault", {31'b0, fault_o}, 32'h0);
`else
    // PC increment wraps past the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_pre", im_addr_o, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_addr", im_addr_o, 32'h0);
    chk("wrap_pc", if_pc_o, 32'hFFFF_FFFC);
    // Misaligned target is forced to a word boundary.
    step(1'b1, 32'h27, 1'b1);
    chk("align_addr", im_addr_o, 32'h24);
`endif

    // Async reset in the middle of a stall.
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    pulse_reset(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      lo  = 2'($urandom_range(0, 3));
      rpc = {23'b0, 7'($urandom_range(0, (MEM_SIZE / 4) - 1)), 2'b00};
      if (!CHK || $urandom_range(0, 15) == 0) rpc[1:0] = lo;
      if (!CHK && $urandom_range(0, 20) == 0) rpc = rpc | 32'hFFFF_FF00;
      if ((m_phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 150) == 0)
        pulse_reset(1'b0);
      else
        step(1'($urandom_range(0, 9) == 0), rpc, 1'($urandom_range(0, 3) != 0));
    end

    run_checks = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter MEM_SIZE, default 128, instruction memory size in bytes for the range check.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port im_addr_o, output, BUS_W, byte address to instruction memory; combinational copy of pc_q.
REQ-006 SHALL have port im_inst_i, input, BUS_W, little-endian instruction word returned combinationally for im_addr_o.
REQ-007 SHALL have port redirect_valid_i, input, 1, branch/jump taken from a later stage.
REQ-008 SHALL have port redirect_pc_i, input, BUS_W, redirect target.
REQ-009 SHALL have port id_ready_i, input, 1, decode stage accepts the IF/ID word this cycle.
REQ-010 SHALL have port if_valid_o, output, 1, IF/ID register holds a valid instruction.
REQ-011 SHALL have port if_inst_o, output, BUS_W, registered instruction.
REQ-012 SHALL have port if_pc_o, output, BUS_W, address of if_inst_o.
REQ-013 SHALL have port fault_o, output, 1, sticky fetch fault; constant 0 when RVX_FETCH_CHK_EN is undefined.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, HALT; BOOT lasts exactly one cycle after rst_n deassertion, then RUN.
REQ-015 In BOOT: no capture, if_valid_o stays 0, pc_q holds RESET_PC; a redirect in BOOT loads pc_q and moves to RUN.
REQ-016 Slot free SHALL be defined as (!if_valid_o || id_ready_i).
REQ-017 In RUN with redirect_valid_i=1: pc_q <= redirect_pc_i, if_valid_o <= 0 next cycle (wrong-path kill), regardless of id_ready_i.
REQ-018 In RUN without redirect and slot free: if_inst_o <= im_inst_i, if_pc_o <= pc_q, if_valid_o <= 1, pc_q <= pc_q + 4.
REQ-019 In RUN without redirect and slot not free: pc_q, if_inst_o, if_pc_o, if_valid_o SHALL hold (stall).
REQ-020 Latency: instruction at address A SHALL appear on if_inst_o the cycle after pc_q = A; throughput one per cycle when id_ready_i=1.
REQ-021 pc_q + 4 SHALL wrap modulo 2^BUS_W; no carry out.
REQ-022 Redirect and id_ready_i both high: current word counts consumed; next word killed.
REQ-023 In HALT: if_valid_o=0, pc_q frozen, redirects ignored; exit only by reset.

Reset
REQ-024 On rst_n=0, immediately: state=BOOT, pc_q=RESET_PC, if_valid_o=0, if_inst_o=32'h0000_0013 (NOP), if_pc_o=0, fault_o=0.
REQ-025 Reset mid-stall or mid-redirect SHALL discard all in-flight state.

Configuration
REQ-026 Macro RVX_FETCH_CHK_EN defined: a redirect with target[1:0]!=0, or pc_q > MEM_SIZE-4 in RUN, SHALL set fault_o=1 and enter HALT next cycle without capturing.
REQ-027 Macro undefined: no HALT entry; redirect target bits [1:0] forced to 0; out-of-range addresses fetched unchecked; fault_o tied 0.

Structure
REQ-028 Shared package rvx_pkg SHALL hold BUS_W (32), NOP encoding 32'h0000_0013, fetch FSM state enum.
REQ-029 The IF/ID register (valid/inst/pc with load, hold, kill) SHALL be a sub-module if_id_reg; PC and FSM remain in fetch_unit.

Verification
REQ-030 Reset release, id_ready_i=1, memory words 0x00500513, 0x00158593 at 0, 4 -> if_valid_o rises cycle 2, if_pc_o 0 then 4, inst matches.
REQ-031 id_ready_i=0 for 3 cycles with if_valid_o=1 -> if_inst_o, if_pc_o, im_addr_o unchanged; resume without loss or duplication.
REQ-032 Redirect to 0x4 while pc_q=0x10 -> next cycle if_valid_o=0, im_addr_o=0x4; following cycle if_pc_o=0x4.
REQ-033 pc_q=0xFFFF_FFFC, macro undefined -> next pc_q=0x0000_0000.
REQ-034 Macro defined, redirect to 0x6 -> fault_o=1, HALT, if_valid_o=0; later redirect to 0x0 ignored; rst_n pulse clears fault_o.
REQ-035 rst_n asserted asynchronously mid-stall -> outputs at REQ-024 values before next clock edge.
